// File: rtl/io_peripheral.sv
// io_peripheral: memory-mapped switches, debounced buttons with sticky edges, LED register, cycle timer and ID word.
// Define IO_PERIPH_IRQ_EN to add the IRQ_MASK register at 0x20 and the irq output.
module io_peripheral #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 5,
    parameter int          NUM_LED         = 16,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] ID_VALUE        = 32'h494F_0001
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        io_address,
    input  logic [31:0]        io_write_value,
    output logic [31:0]        io_read_value,
    input  logic               io_write_en,
    input  logic               io_read_en,
    input  logic [2:0]         io_data_size,
    input  logic [NUM_SW-1:0]  sw,
    input  logic [NUM_BTN-1:0] btn,
    output logic [NUM_LED-1:0] led
`ifdef IO_PERIPH_IRQ_EN
    ,
    output logic               irq
`endif
);
    localparam int              PS_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] OFF_SW    = 4'h0;
    localparam logic [3:0] OFF_BTN   = 4'h1;
    localparam logic [3:0] OFF_EDGE  = 4'h2;
    localparam logic [3:0] OFF_LED   = 4'h3;
    localparam logic [3:0] OFF_SET   = 4'h4;
    localparam logic [3:0] OFF_CLR   = 4'h5;
    localparam logic [3:0] OFF_TIMER = 4'h6;
    localparam logic [3:0] OFF_ID    = 4'h7;
    localparam logic [3:0] OFF_MASK  = 4'h8;

    logic [NUM_SW-1:0]  sw_meta, sw_s;
    logic [NUM_BTN-1:0] btn_meta, btn_s, sample, btn_db, edge_flags;
    logic [NUM_BTN-1:0] agree, db_next, rise, edge_clr, edge_next;
    logic [PS_W-1:0]    prescaler;
    logic               tick;
    logic [31:0]        timer, rd_data, led_wide, lane_wide;
    logic [NUM_LED-1:0] led_next;
    logic [3:0]         offset;
    logic               hit, wr_edge, wr_led, wr_set, wr_clr;
    logic               unused_lane;

    assign offset  = io_address[5:2];
    assign hit     = (io_address[31:6] == BASE_ADDR[31:6]);
    assign tick    = (prescaler == PS_MAX);
    assign wr_edge = io_write_en && hit && (offset == OFF_EDGE);
    assign wr_led  = io_write_en && hit && (offset == OFF_LED);
    assign wr_set  = io_write_en && hit && (offset == OFF_SET);
    assign wr_clr  = io_write_en && hit && (offset == OFF_CLR);

    // A debounced bit only moves when two consecutive tick samples agree; a
    // rising debounced bit sets its edge flag in the same cycle, and wins over a W1C.
    always_comb begin
        agree   = ~(btn_s ^ sample);
        db_next = btn_db;
        if (tick)
            db_next = (agree & sample) | (~agree & btn_db);
        rise      = db_next & ~btn_db;
        edge_clr  = wr_edge ? io_write_value[NUM_BTN-1:0] : {NUM_BTN{1'b0}};
        edge_next = (edge_flags & ~edge_clr) | rise;
    end

    // LED lanes are merged in a 32-bit view so lanes above NUM_LED fall away on truncation.
    always_comb begin
        led_wide              = '0;
        led_wide[NUM_LED-1:0] = led;
        lane_wide             = led_wide;
        case (io_data_size)
            3'b000:  lane_wide[{io_address[1:0], 3'b000} +: 8] = io_write_value[7:0];
            3'b001:  lane_wide[{io_address[1], 4'b0000} +: 16] = io_write_value[15:0];
            default: lane_wide = io_write_value;
        endcase
        led_next = led;
        if (wr_led)
            led_next = lane_wide[NUM_LED-1:0];
        else if (wr_set)
            led_next = led | io_write_value[NUM_LED-1:0];
        else if (wr_clr)
            led_next = led & ~io_write_value[NUM_LED-1:0];
    end

    assign unused_lane = ^lane_wide;

`ifdef IO_PERIPH_IRQ_EN
    logic [NUM_BTN-1:0] irq_mask;
    logic               wr_mask;
    assign wr_mask = io_write_en && hit && (offset == OFF_MASK);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_mask)
                irq_mask <= io_write_value[NUM_BTN-1:0];
            irq <= |(edge_flags & irq_mask);
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (offset)
                OFF_SW:    rd_data[NUM_SW-1:0]  = sw_s;
                OFF_BTN:   rd_data[NUM_BTN-1:0] = btn_db;
                OFF_EDGE:  rd_data[NUM_BTN-1:0] = edge_flags;
                OFF_LED:   rd_data[NUM_LED-1:0] = led;
                OFF_TIMER: rd_data = timer;
                OFF_ID:    rd_data = ID_VALUE;
`ifdef IO_PERIPH_IRQ_EN
                OFF_MASK:  rd_data[NUM_BTN-1:0] = irq_mask;
`endif
                default:   rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_meta       <= '0;
            sw_s          <= '0;
            btn_meta      <= '0;
            btn_s         <= '0;
            prescaler     <= '0;
            sample        <= '0;
            btn_db        <= '0;
            edge_flags    <= '0;
            led           <= '0;
            timer         <= '0;
            io_read_value <= '0;
        end else begin
            sw_meta    <= sw;
            sw_s       <= sw_meta;
            btn_meta   <= btn;
            btn_s      <= btn_meta;
            prescaler  <= tick ? '0 : prescaler + PS_W'(1);
            if (tick)
                sample <= btn_s;
            btn_db     <= db_next;
            edge_flags <= edge_next;
            led        <= led_next;
            timer      <= timer + 32'd1;
            if (io_read_en)
                io_read_value <= rd_data;
        end
    end
endmodule

// File: tb/tb_io_peripheral.sv
// tb_io_peripheral: randomized and directed checks of io_peripheral against a behavioural model.
// Build with IO_PERIPH_IRQ_EN defined to exercise the irq output.
module tb_io_peripheral;
    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] io_address = '0;
    logic [31:0] io_write_value = '0;
    logic [31:0] io_read_value;
    logic        io_write_en = 1'b0;
    logic        io_read_en = 1'b0;
    logic [2:0]  io_data_size = 3'b010;
    logic [15:0] sw = '0;
    logic [4:0]  btn = '0;
    logic [15:0] led;
`ifdef IO_PERIPH_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [15:0] led_ref = '0;

    io_peripheral #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk),
        .reset(reset),
        .io_address(io_address),
        .io_write_value(io_write_value),
        .io_read_value(io_read_value),
        .io_write_en(io_write_en),
        .io_read_en(io_read_en),
        .io_data_size(io_data_size),
        .sw(sw),
        .btn(btn),
        .led(led)
`ifdef IO_PERIPH_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    // Counts clock edges since reset was released; edge n sees debounce phase n mod DEB.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        led_ref = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        io_address = addr;
        io_read_en = 1'b1;
        @(negedge clk);
        data = io_read_value;
        io_read_en = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] val, input logic [2:0] size);
        io_address     = addr;
        io_write_value = val;
        io_data_size   = size;
        io_write_en    = 1'b1;
        @(negedge clk);
        io_write_en    = 1'b0;
        io_data_size   = 3'b010;
    endtask

    // Edge index at which a press first applied before edge c0 lifts the debounced level.
    function automatic int rise_edge(input int c0);
        int t = c0 + 2;
        while (t % DEB != DEB - 1) t++;
        return t + DEB;
    endfunction

    function automatic logic [15:0] led_model(input logic [15:0] cur, input logic [31:0] addr,
                                              input logic [31:0] val, input logic [2:0] size);
        logic [31:0] wide;
        case (addr[5:2])
            4'h3: begin
                wide = {16'h0000, cur};
                if (size == 3'b000)      wide[addr[1:0]*8 +: 8] = val[7:0];
                else if (size == 3'b001) wide[addr[1]*16 +: 16] = val[15:0];
                else                     wide = val;
                return wide[15:0];
            end
            4'h4:    return cur | val[15:0];
            4'h5:    return cur & ~val[15:0];
            default: return cur;
        endcase
    endfunction

    task automatic test_reset();
        logic [31:0] d, t1, t2;
        int          c_first;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (led !== 16'h0 || io_read_value !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_state led=%h rd=%h required 0/0", led, io_read_value);
        end
        do_reset();
        bus_read(32'h1C, d);
        checks++;
        if (d !== 32'h494F_0001) begin
            failures++;
            $display("[TB] FAIL id got=%h required=494f0001", d);
        end
        c_first = cyc;
        bus_read(32'h18, t1);
        checks++;
        if (t1 !== 32'(c_first)) begin
            failures++;
            $display("[TB] FAIL timer_start got=%0d required=%0d", t1, c_first);
        end
        repeat (9) @(negedge clk);
        bus_read(32'h18, t2);
        checks++;
        if (t2 !== t1 + 32'd10) begin
            failures++;
            $display("[TB] FAIL timer_gap got=%0d required=%0d", t2, t1 + 32'd10);
        end
        io_address = 32'h1C;
        repeat (3) @(negedge clk);
        checks++;
        if (io_read_value !== t2 || led !== 16'h0) begin
            failures++;
            $display("[TB] FAIL read_hold rd=%h led=%h required %h/0000", io_read_value, led, t2);
        end
    endtask

    task automatic test_switches();
        logic [31:0] d;
        for (int i = 0; i < 5; i++) begin
            sw = (i == 0) ? 16'hA5C3 : 16'($urandom);
            repeat (3) @(negedge clk);
            bus_read(32'h00, d);
            checks++;
            if (d !== {16'h0000, sw}) begin
                failures++;
                $display("[TB] FAIL sw_read[%0d] got=%h required=%h", i, d, {16'h0000, sw});
            end
        end
    endtask

    task automatic test_buttons();
        logic [31:0] d;
        btn = 5'b00100;
        repeat (12) @(negedge clk);
        bus_read(32'h04, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL btn_level got=%h required=00000004", d);
        end
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL edge_set got=%h required=00000004", d);
        end
        btn = '0;
        repeat (20) @(negedge clk);
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h4) begin
            failures++;
            $display("[TB] FAIL edge_sticky got=%h required=00000004", d);
        end
        bus_write(32'h08, 32'h4, 3'b010);
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL edge_w1c got=%h required=00000000", d);
        end
        btn = 5'b00001;
        repeat (2) @(negedge clk);
        btn = '0;
        repeat (12) @(negedge clk);
        bus_read(32'h04, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL glitch_btn got=%h required=00000000", d);
        end
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL glitch_edge got=%h required=00000000", d);
        end
    endtask

    task automatic test_led();
        logic [31:0] addr, val;
        logic [2:0]  size;
        int          op;
        bus_write(32'h0C, 32'h0000_F00F, 3'b010);
        bus_write(32'h10, 32'h0000_0F00, 3'b010);
        bus_write(32'h14, 32'h0000_000F, 3'b010);
        bus_write(32'h0D, 32'h0000_00AA, 3'b000);
        checks++;
        if (led !== 16'hAA00) begin
            failures++;
            $display("[TB] FAIL led_sequence got=%h required=aa00", led);
        end
        led_ref = 16'hAA00;
        for (int i = 0; i < 24; i++) begin
            op  = $urandom_range(4, 0);
            val = $urandom;
            case (op)
                0:       begin addr = 32'h0C; size = 3'b010; end
                1:       begin addr = 32'h0C + 32'($urandom_range(1, 0) * 2); size = 3'b001; end
                2:       begin addr = 32'h0C + 32'($urandom_range(3, 0)); size = 3'b000; end
                3:       begin addr = 32'h10; size = 3'b010; end
                default: begin addr = 32'h14; size = 3'b010; end
            endcase
            led_ref = led_model(led_ref, addr, val, size);
            bus_write(addr, val, size);
            checks++;
            if (led !== led_ref) begin
                failures++;
                $display("[TB] FAIL led_random[%0d] addr=%h size=%0d got=%h required=%h",
                         i, addr, size, led, led_ref);
            end
        end
        bus_read(32'h0C, val);
        checks++;
        if (val !== {16'h0000, led_ref}) begin
            failures++;
            $display("[TB] FAIL led_readback got=%h required=%h", val, {16'h0000, led_ref});
        end
        bus_write(32'h4C, 32'h0000_5A5A, 3'b010);
        checks++;
        if (led !== led_ref) begin
            failures++;
            $display("[TB] FAIL led_miss_write got=%h required=%h", led, led_ref);
        end
        bus_write(32'h0C, 32'h0000_1234, 3'b010);
        do_reset();
        checks++;
        if (led !== 16'h0) begin
            failures++;
            $display("[TB] FAIL led_reset got=%h required=0000", led);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        int          r;
        r   = rise_edge(cyc);
        btn = 5'b00010;
        repeat (r - 1 - cyc) @(negedge clk);
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL edge_early got=%h required=00000000", d);
        end
        bus_write(32'h08, 32'h2, 3'b010);
        bus_read(32'h08, d);
        checks++;
        if (d !== 32'h2) begin
            failures++;
            $display("[TB] FAIL edge_set_wins got=%h required=00000002", d);
        end
        btn = '0;
        bus_read(32'h3C, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL unmapped_read got=%h required=00000000", d);
        end
        bus_read(32'h5C, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL base_miss_read got=%h required=00000000", d);
        end
        repeat (20) @(negedge clk);
        bus_write(32'h08, 32'h1F, 3'b010);
    endtask

    task automatic test_irq();
        logic [31:0] d;
`ifdef IO_PERIPH_IRQ_EN
        int r;
        bus_write(32'h20, 32'h1, 3'b010);
        bus_read(32'h20, d);
        checks++;
        if (d !== 32'h1) begin
            failures++;
            $display("[TB] FAIL irq_mask_read got=%h required=00000001", d);
        end
        r   = rise_edge(cyc);
        btn = 5'b00001;
        repeat (r + 1 - cyc) @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_same_cycle got=%b required=0", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL irq_rise got=%b required=1", irq);
        end
        bus_write(32'h08, 32'h1, 3'b010);
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("[TB] FAIL irq_hold got=%b required=1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_fall got=%b required=0", irq);
        end
        btn = '0;
        repeat (20) @(negedge clk);
`else
        bus_write(32'h20, 32'h1F, 3'b010);
        bus_read(32'h20, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("[TB] FAIL mask_absent got=%h required=00000000", d);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_switches();
        test_buttons();
        test_led();
        test_same_cycle();
        test_irq();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
